// File: rtl/conv_kxk_stream_multich.sv
// conv_kxk_stream_multich
//   Streaming KxK convolution over a raster-scanned I_SIZE x I_SIZE plane.
//   Each pass produces one output channel. There are CO passes per layer.
//   Weights for channel o_co_idx are latched when a pass starts.
//   Products and a binary adder tree are fully registered.
//   o_conv_valid follows an emitting pixel accept by exactly
//   LAT = 2 + clog2(K_SIZE*K_SIZE) cycles.
//
//   Optional feature: define CONV_RELU_EN to clamp negative sums to zero in the
//   output register. Latency does not change.
//
// Ports
//   clk, global_rst_n        clock, asynchronous active-low reset
//   user_reset               synchronous clear of all state incl. channel index
//   i_start                  begin/restart a pass, latch weights of o_co_idx
//   i_valid, i_fmap          pixel stream, raster order
//   i_weight                 all kernels; tap k of ch c at [(c*K*K+k)*W_BW +: W_BW]
//   o_conv_result/valid      convolution result and its strobe
//   o_conv_end               pulse with the last result of a pass
//   o_conv_all_end           level: all CO passes done
//   o_busy                   pass active or pipeline non-empty
//   o_co_idx                 channel of the current/next pass
//
// Handshake: a pixel is consumed on every rising edge where i_valid is high and
// the engine is in RUN. There is no backpressure. Results are presented for
// exactly one cycle with o_conv_valid.
module conv_kxk_stream_multich #(
  parameter int I_BW      = 8,
  parameter int W_BW      = 8,
  parameter int O_CONV_BW = 20,
  parameter int I_SIZE    = 28,
  parameter int K_SIZE    = 5,
  parameter int STRIDE    = 1,
  parameter int CO        = 4
) (
  input  logic                              clk,
  input  logic                              global_rst_n,
  input  logic                              user_reset,
  input  logic                              i_start,
  input  logic                              i_valid,
  input  logic [I_BW-1:0]                   i_fmap,
  input  logic [CO*K_SIZE*K_SIZE*W_BW-1:0]  i_weight,
  output logic [O_CONV_BW-1:0]              o_conv_result,
  output logic                              o_conv_valid,
  output logic                              o_conv_end,
  output logic                              o_conv_all_end,
  output logic                              o_busy,
  output logic [$clog2(CO):0]               o_co_idx
);

  localparam int KK     = K_SIZE * K_SIZE;
  localparam int L      = $clog2(KK);          // adder tree depth
  localparam int NP     = 1 << L;              // tree width padded to a power of two
  localparam int SR_LEN = (K_SIZE - 1) * I_SIZE + K_SIZE;
  localparam int CNT_W  = $clog2(I_SIZE);
  localparam int CO_W   = $clog2(CO) + 1;
  localparam int P_BW   = I_BW + W_BW;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]           row_q, col_q;
  logic signed [I_BW-1:0]     sr_q   [0:SR_LEN-1];  // line buffers + window, sr_q[0] newest
  logic signed [W_BW-1:0]     w_q    [0:KK-1];
  logic signed [P_BW-1:0]     prod_w [0:KK-1];
  logic signed [O_CONV_BW-1:0] tree_q [0:L][0:NP-1];
  logic                       emit_q, emit_last_q;
  logic [L:0]                 vld_q, last_q;
  logic [O_CONV_BW-1:0]       res_q;
  logic                       valid_q, end_q;
  logic [CO_W-1:0]            co_q;

  logic start_ok, accept, last_pix, emit_d;

  // A start is taken in any state unless all channels are finished.
  assign start_ok = i_start & ~user_reset &
                    ((state_q != ST_IDLE) | (co_q < CO_W'(CO)));
  assign accept   = i_valid & (state_q == ST_RUN) & ~user_reset & ~start_ok;
  assign last_pix = (row_q == CNT_W'(I_SIZE - 1)) && (col_q == CNT_W'(I_SIZE - 1));

  // The pixel being accepted is the bottom-right corner of the candidate window.
  always_comb begin
    emit_d = 1'b0;
    if (int'(row_q) >= K_SIZE - 1 && int'(col_q) >= K_SIZE - 1)
      emit_d = ((int'(row_q) - (K_SIZE - 1)) % STRIDE == 0) &&
               ((int'(col_q) - (K_SIZE - 1)) % STRIDE == 0);
  end

  // Tap k=(ki,kj) sits (K-1-ki) lines and (K-1-kj) pixels behind the newest pixel.
  always_comb begin
    for (int k = 0; k < KK; k++)
      prod_w[k] = P_BW'(sr_q[(K_SIZE - 1 - k / K_SIZE) * I_SIZE + (K_SIZE - 1 - k % K_SIZE)])
                * P_BW'(w_q[k]);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (user_reset)    state_d = ST_IDLE;
    else if (start_ok) state_d = ST_RUN;
    else begin
      case (state_q)
        ST_RUN:   if (accept && last_pix) state_d = ST_DRAIN;
        ST_DRAIN: if (last_q[L])          state_d = ST_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    o_busy         = (state_q != ST_IDLE) | emit_q | (|vld_q);
    o_conv_all_end = (co_q == CO_W'(CO));
  end

  assign o_conv_result = res_q;
  assign o_conv_valid  = valid_q;
  assign o_conv_end    = end_q;
  assign o_co_idx      = co_q;

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      row_q <= '0; col_q <= '0; emit_q <= 1'b0; emit_last_q <= 1'b0;
      vld_q <= '0; last_q <= '0; res_q <= '0; valid_q <= 1'b0; end_q <= 1'b0;
      co_q  <= '0;
      for (int i = 0; i < SR_LEN; i++) sr_q[i] <= '0;
      for (int k = 0; k < KK; k++) w_q[k] <= '0;
      for (int l = 0; l <= L; l++)
        for (int i = 0; i < NP; i++) tree_q[l][i] <= '0;
    end else if (user_reset) begin
      row_q <= '0; col_q <= '0; emit_q <= 1'b0; emit_last_q <= 1'b0;
      vld_q <= '0; last_q <= '0; res_q <= '0; valid_q <= 1'b0; end_q <= 1'b0;
      co_q  <= '0;
      for (int i = 0; i < SR_LEN; i++) sr_q[i] <= '0;
      for (int k = 0; k < KK; k++) w_q[k] <= '0;
      for (int l = 0; l <= L; l++)
        for (int i = 0; i < NP; i++) tree_q[l][i] <= '0;
    end else begin
      // Arithmetic pipeline advances every cycle, independent of i_valid.
      vld_q  <= {vld_q[L-1:0], emit_q};
      last_q <= {last_q[L-1:0], emit_last_q};
      for (int i = 0; i < NP; i++)
        tree_q[0][i] <= (i < KK) ? O_CONV_BW'(prod_w[i]) : '0;
      for (int l = 0; l < L; l++) begin
        for (int i = 0; i < NP / 2; i++)
          tree_q[l+1][i] <= tree_q[l][2*i] + tree_q[l][2*i+1];
        for (int i = NP / 2; i < NP; i++)
          tree_q[l+1][i] <= '0;
      end
      valid_q <= vld_q[L];
      end_q   <= last_q[L];
      if (vld_q[L]) begin
`ifdef CONV_RELU_EN
        res_q <= tree_q[L][0][O_CONV_BW-1] ? '0 : tree_q[L][0];
`else
        res_q <= tree_q[L][0];
`endif
      end
      if (last_q[L]) co_q <= co_q + 1'b1;

      // Window/line-buffer shift only on an accepted pixel.
      emit_q      <= 1'b0;
      emit_last_q <= 1'b0;
      if (accept) begin
        sr_q[0] <= i_fmap;
        for (int i = 1; i < SR_LEN; i++) sr_q[i] <= sr_q[i-1];
        emit_q      <= emit_d;
        emit_last_q <= emit_d & last_pix;
        if (col_q == CNT_W'(I_SIZE - 1)) begin
          col_q <= '0;
          row_q <= last_pix ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      // (Re)start overrides everything above: in-flight results of an aborted
      // pass are dropped, and no end pulse or channel increment is produced.
      if (start_ok) begin
        row_q <= '0; col_q <= '0; emit_q <= 1'b0; emit_last_q <= 1'b0;
        vld_q <= '0; last_q <= '0; valid_q <= 1'b0; end_q <= 1'b0;
        co_q  <= co_q;
        for (int i = 0; i < SR_LEN; i++) sr_q[i] <= '0;
        for (int k = 0; k < KK; k++)
          w_q[k] <= i_weight[(int'(co_q) * KK + k) * W_BW +: W_BW];
      end
    end
  end

endmodule

// File: tb/tb_conv_kxk_stream_multich.sv
module tb_conv_kxk_stream_multich;

  localparam int IA = 6, SA = 1, COA = 2;
  localparam int IB = 7, SB = 2;
  localparam int K = 3, LAT = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: 6x6, K=3, S=1, CO=2 ----------------
  logic         a_user_reset, a_start, a_valid;
  logic [7:0]   a_fmap;
  logic [143:0] a_weight;
  logic [19:0]  a_res;
  logic         a_cv, a_ce, a_ae, a_busy;
  logic [1:0]   a_co;

  conv_kxk_stream_multich #(.I_BW(8), .W_BW(8), .O_CONV_BW(20), .I_SIZE(IA),
    .K_SIZE(K), .STRIDE(SA), .CO(COA)) dut_a (
    .clk(clk), .global_rst_n(rst_n), .user_reset(a_user_reset), .i_start(a_start),
    .i_valid(a_valid), .i_fmap(a_fmap), .i_weight(a_weight),
    .o_conv_result(a_res), .o_conv_valid(a_cv), .o_conv_end(a_ce),
    .o_conv_all_end(a_ae), .o_busy(a_busy), .o_co_idx(a_co));

  // ---------------- DUT B: 7x7, K=3, S=2, CO=1 ----------------
  logic         b_user_reset, b_start, b_valid;
  logic [7:0]   b_fmap;
  logic [71:0]  b_weight;
  logic [19:0]  b_res;
  logic         b_cv, b_ce, b_ae, b_busy;
  logic [0:0]   b_co;

  conv_kxk_stream_multich #(.I_BW(8), .W_BW(8), .O_CONV_BW(20), .I_SIZE(IB),
    .K_SIZE(K), .STRIDE(SB), .CO(1)) dut_b (
    .clk(clk), .global_rst_n(rst_n), .user_reset(b_user_reset), .i_start(b_start),
    .i_valid(b_valid), .i_fmap(b_fmap), .i_weight(b_weight),
    .o_conv_result(b_res), .o_conv_valid(b_cv), .o_conv_end(b_ce),
    .o_conv_all_end(b_ae), .o_busy(b_busy), .o_co_idx(b_co));

  // ---------------- scoreboard state ----------------
  int pix [0:48];
  int wm  [0:8];
  logic [19:0] exp_q[$];
  int          exp_cyc_q[$];
  logic        exp_end_q[$];
  logic [19:0] exp_b_q[$];
  logic        exp_b_end_q[$];
  int exp_co_end;
  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, $signed(got), got, $signed(exp), exp, cyc);
    end
  endtask

  // Reference: direct 3x3 correlation with the window's bottom-right at (r,c).
  function automatic int model(input int isz, input int r, input int c);
    int s = 0;
    for (int ki = 0; ki < K; ki++)
      for (int kj = 0; kj < K; kj++)
        s += pix[(r - K + 1 + ki) * isz + (c - K + 1 + kj)] * wm[ki * K + kj];
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  function automatic bit emits(input int isz, input int s, input int idx);
    int r = idx / isz;
    int c = idx % isz;
    return (r >= K - 1) && (c >= K - 1) && ((r - K + 1) % s == 0) && ((c - K + 1) % s == 0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_a_ch(input int ch, input int base, input int step);
    for (int k = 0; k < 9; k++) a_weight[(ch * 9 + k) * 8 +: 8] = 8'(base + step * k);
  endtask

  task automatic set_wm(input int base, input int step);
    for (int k = 0; k < 9; k++) wm[k] = base + step * k;
  endtask

  task automatic pulse_start_a();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
  endtask

  task automatic pulse_user_reset_a();
    @(negedge clk) a_user_reset = 1'b1;
    @(negedge clk) a_user_reset = 1'b0;
  endtask

  // rnd!=0: i_valid random at 50%. push: record expectations. scribble: alter
  // i_weight mid-pass (must have no effect on results).
  task automatic drive_a(input int rnd, input int npix, input bit push, input bit scribble);
    int idx = 0;
    while (idx < npix) begin
      @(negedge clk);
      if (rnd != 0 && $urandom_range(0, 1) == 0) begin
        a_valid = 1'b0;
        a_fmap  = 8'($urandom_range(0, 255));
      end else begin
        a_valid = 1'b1;
        a_fmap  = 8'(pix[idx]);
        if (scribble && idx == 10) a_weight = ~a_weight;
        if (push && emits(IA, SA, idx)) begin
          exp_q.push_back(20'(model(IA, idx / IA, idx % IA)));
          exp_cyc_q.push_back(cyc + 1 + LAT);
          exp_end_q.push_back(idx == IA * IA - 1);
        end
        idx++;
      end
    end
    @(negedge clk) a_valid = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || a_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check({tag, "_timeout"}, 1, 0);
    repeat (2) @(negedge clk);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_a
    logic [19:0] e;
    int ec;
    logic ee;
    if (rst_n) begin
      if (a_cv) begin
        if (exp_q.size() == 0) check("a_unexpected_valid", 1, 0);
        else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          ee = exp_end_q.pop_front();
          check("a_result", 32'($signed(a_res)), 32'($signed(e)));
          check("a_latency_cycle", cyc, ec);
          check("a_conv_end", 32'(a_ce), 32'(ee));
          if (ee) begin
            check("a_co_idx_at_end", 32'(a_co), exp_co_end);
            check("a_all_end_at_end", 32'(a_ae), 32'(exp_co_end == COA));
          end
        end
      end else if (a_ce) check("a_end_without_valid", 1, 0);
    end
  end

  always @(negedge clk) begin : mon_b
    logic [19:0] e;
    logic ee;
    if (rst_n && b_cv) begin
      if (exp_b_q.size() == 0) check("b_unexpected_valid", 1, 0);
      else begin
        e  = exp_b_q.pop_front();
        ee = exp_b_end_q.pop_front();
        check("b_result", 32'($signed(b_res)), 32'($signed(e)));
        check("b_conv_end", 32'(b_ce), 32'(ee));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    a_user_reset = 0; a_start = 0; a_valid = 0; a_fmap = '0; a_weight = '0;
    b_user_reset = 0; b_start = 0; b_valid = 0; b_fmap = '0; b_weight = '0;
    for (int i = 0; i < 49; i++) pix[i] = i;
    set_a_ch(0, 1, 0);
    set_a_ch(1, -4, 1);
    for (int k = 0; k < 9; k++) b_weight[k * 8 +: 8] = 8'd1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_result", 32'(a_res), 0);
    check("rst_valid", 32'(a_cv), 0);
    check("rst_end", 32'(a_ce), 0);
    check("rst_all_end", 32'(a_ae), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_co_idx", 32'(a_co), 0);
    check("rst_b_valid", 32'(b_cv), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: all ones, ramp, continuous valid
    set_wm(1, 0);
    exp_co_end = 1;
    pulse_start_a();
    check("t1_busy_after_start", 32'(a_busy), 1);
    drive_a(0, 36, 1'b1, 1'b0);
    wait_done_a("t1");
    check("t1_co_idx", 32'(a_co), 1);
    check("t1_all_end", 32'(a_ae), 0);
    check("t1_busy_idle", 32'(a_busy), 0);

    // T2: same data, random i_valid, weights scribbled mid-pass
    pulse_user_reset_a();
    check("ureset_co_idx", 32'(a_co), 0);
    exp_co_end = 1;
    pulse_start_a();
    drive_a(1, 36, 1'b1, 1'b1);
    set_a_ch(0, 1, 0);
    set_a_ch(1, -4, 1);
    wait_done_a("t2");
    check("t2_co_idx", 32'(a_co), 1);

    // T5: second channel with a distinct kernel, completes the layer
    set_wm(-4, 1);
    exp_co_end = 2;
    pulse_start_a();
    drive_a(0, 36, 1'b1, 1'b0);
    wait_done_a("t5");
    check("t5_co_idx", 32'(a_co), 2);
    check("t5_all_end", 32'(a_ae), 1);

    // Third start must be ignored
    pulse_start_a();
    check("t5_ignored_busy", 32'(a_busy), 0);
    drive_a(0, 36, 1'b0, 1'b0);
    wait_done_a("t5_ignored");
    check("t5_ignored_co_idx", 32'(a_co), 2);

    pulse_user_reset_a();
    check("ureset2_co_idx", 32'(a_co), 0);
    check("ureset2_all_end", 32'(a_ae), 0);

    // Abort: restart while two emitted windows are still in flight
    set_wm(1, 0);
    exp_co_end = 1;
    pulse_start_a();
    drive_a(0, 16, 1'b0, 1'b0);
    pulse_start_a();
    check("abort_co_idx", 32'(a_co), 0);
    drive_a(0, 36, 1'b1, 1'b0);
    wait_done_a("abort");
    check("abort_co_after", 32'(a_co), 1);

    // T4: all weights -1
    pulse_user_reset_a();
    set_a_ch(0, -1, 0);
    set_wm(-1, 0);
    exp_co_end = 1;
    pulse_start_a();
    drive_a(0, 36, 1'b1, 1'b0);
    wait_done_a("t4");
    set_a_ch(0, 1, 0);

    // T6: global reset mid-pass, then a fresh pass
    pulse_start_a();
    drive_a(0, 16, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t6_rst_valid", 32'(a_cv), 0);
      check("t6_rst_result", 32'(a_res), 0);
      check("t6_rst_busy", 32'(a_busy), 0);
      check("t6_rst_co_idx", 32'(a_co), 0);
    end
    rst_n = 1'b1;
    set_wm(1, 0);
    exp_co_end = 1;
    repeat (LAT + 2) @(negedge clk);
    pulse_start_a();
    drive_a(0, 36, 1'b1, 1'b0);
    wait_done_a("t6");

    // T3: stride 2 on 7x7
    set_wm(1, 0);
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    for (int idx = 0; idx < 49; idx++) begin
      @(negedge clk);
      b_valid = 1'b1;
      b_fmap  = 8'(pix[idx]);
      if (emits(IB, SB, idx)) begin
        exp_b_q.push_back(20'(model(IB, idx / IB, idx % IB)));
        exp_b_end_q.push_back(idx == 48);
      end
    end
    @(negedge clk) b_valid = 1'b0;
    begin
      int n = 0;
      while ((exp_b_q.size() != 0 || b_busy) && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) check("t3_timeout", 1, 0);
    end
    repeat (2) @(negedge clk);
    check("t3_drained", exp_b_q.size(), 0);
    check("t3_co_idx", 32'(b_co), 1);
    check("t3_all_end", 32'(b_ae), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
